// File: rtl/multi_lane_vehicle_counter.sv
// Per-lane S1/S2 direction detectors with stuck-sensor timeout, feeding one shared
// lot occupancy counter clamped to [0, CAPACITY].
//
// state    | meaning
// IDLE     | no vehicle in the lane, waiting for a fresh sensor rise
// S1_ACT   | outer sensor tripped first, vehicle heading in
// S2_ACT   | inner sensor tripped first, vehicle heading out
// ENTER    | entry confirmed, one-cycle pulse on entering[i]
// EXIT     | exit confirmed, one-cycle pulse on exiting[i]
// WAIT_REL | waiting for both sensors to clear
module multi_lane_vehicle_counter #(
  parameter int N_LANES        = 2,
  parameter int CAPACITY       = 15,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CNT_W         = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_LANES-1:0] s1,
  input  logic [N_LANES-1:0] s2,
  output logic [N_LANES-1:0] entering,
  output logic [N_LANES-1:0] exiting,
  output logic [N_LANES-1:0] lane_fault,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic               overflow_err,
  output logic               underflow_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = CNT_W + $clog2(N_LANES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE, S1_ACT, S2_ACT, ENTER, EXIT, WAIT_REL
  } lane_state_t;

  lane_state_t state     [N_LANES];
  lane_state_t state_nxt [N_LANES];
  logic [TW-1:0] timer   [N_LANES];

  logic [N_LANES-1:0] s1_q, s2_q, s1_d, s2_d;
  logic [N_LANES-1:0] s1_rise, s1_fall, s2_rise, s2_fall;
  logic [N_LANES-1:0] fault_nxt;

  logic signed [SW-1:0] n_in, n_out, occ_sum;

  assign s1_rise = s1_q & ~s1_d;
  assign s1_fall = ~s1_q & s1_d;
  assign s2_rise = s2_q & ~s2_d;
  assign s2_fall = ~s2_q & s2_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s1_d <= '0;
      s2_d <= '0;
    end else begin
      s1_q <= s1;
      s2_q <= s2;
      s1_d <= s1_q;
      s2_d <= s2_q;
    end
  end

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      state_nxt[i] = state[i];
      fault_nxt[i] = 1'b0;
      case (state[i])
        IDLE: begin
          if (s1_rise[i] && !s2_q[i])      state_nxt[i] = S1_ACT;
          else if (s2_rise[i] && !s1_q[i]) state_nxt[i] = S2_ACT;
        end
        S1_ACT: begin
          if (s2_rise[i])      state_nxt[i] = ENTER;
          else if (s1_fall[i]) state_nxt[i] = IDLE;
          else if (s2_q[i])    state_nxt[i] = EXIT;
          else if (timer[i] == TMO_LAST) begin
            state_nxt[i] = IDLE;
            fault_nxt[i] = 1'b1;
          end
        end
        S2_ACT: begin
          if (s1_rise[i])      state_nxt[i] = EXIT;
          else if (s2_fall[i]) state_nxt[i] = IDLE;
          else if (s1_q[i])    state_nxt[i] = ENTER;
          else if (timer[i] == TMO_LAST) begin
            state_nxt[i] = IDLE;
            fault_nxt[i] = 1'b1;
          end
        end
        ENTER, EXIT: state_nxt[i] = WAIT_REL;
        WAIT_REL: begin
          if (!s1_q[i] && !s2_q[i]) state_nxt[i] = IDLE;
          else if (timer[i] == TMO_LAST) begin
            state_nxt[i] = IDLE;
            fault_nxt[i] = 1'b1;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_LANES; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
      lane_fault <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        state[i] <= state_nxt[i];
        // Dwell timer restarts on every state change so each phase gets the full budget.
        if (state_nxt[i] != state[i])
          timer[i] <= '0;
        else if (state[i] == S1_ACT || state[i] == S2_ACT || state[i] == WAIT_REL)
          timer[i] <= timer[i] + 1'b1;
      end
      lane_fault <= fault_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      entering[i] = (state[i] == ENTER);
      exiting[i]  = (state[i] == EXIT);
    end
  end

  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_in  = n_in + SW'(entering[i]);
      n_out = n_out + SW'(exiting[i]);
    end
    occ_sum = $signed({{(SW - CNT_W){1'b0}}, occupancy}) + n_in - n_out;
  end

  // Simultaneous enters and exits net out before the clamp is applied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy     <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      if (occ_sum > CAP_S) begin
        occupancy    <= CNT_W'(CAPACITY);
        full         <= 1'b1;
        empty        <= 1'b0;
        overflow_err <= 1'b1;
      end else if (occ_sum < 0) begin
        occupancy     <= '0;
        full          <= 1'b0;
        empty         <= 1'b1;
        underflow_err <= 1'b1;
      end else begin
        occupancy <= CNT_W'(occ_sum);
        full      <= (occ_sum == CAP_S);
        empty     <= (occ_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_multi_lane_vehicle_counter.sv
// Directed scenarios plus random sensor traffic, checked every cycle against a
// behavioural lane/occupancy model and a few hand-computed expectations.
module tb_multi_lane_vehicle_counter;

  localparam int N   = 2;
  localparam int CAP = 15;
  localparam int TO  = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] s1, s2;
  logic [N-1:0] entering, exiting, lane_fault;
  logic [3:0]   occupancy;
  logic         full, empty, overflow_err, underflow_err;

  int vectors = 0;
  int miscompares = 0;

  multi_lane_vehicle_counter #(.N_LANES(N), .CAPACITY(CAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .s1(s1), .s2(s2),
    .entering(entering), .exiting(exiting), .lane_fault(lane_fault),
    .occupancy(occupancy), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model phases: what the lane believes is happening, not an RTL encoding.
  localparam int P_IDLE = 0, P_IN = 1, P_OUT = 2, P_ENTERED = 3, P_EXITED = 4, P_CLEAR = 5;

  int       m_phase [N];
  int       m_dwell [N];
  bit       m_fault [N];
  bit [N-1:0] m_s1_now, m_s2_now, m_s1_prev, m_s2_prev;
  int       m_occ;
  bit       m_ovf, m_unf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_phase[i] = P_IDLE; m_dwell[i] = 0; m_fault[i] = 0;
      end
      m_s1_now = '0; m_s2_now = '0; m_s1_prev = '0; m_s2_prev = '0;
      m_occ = 0; m_ovf = 0; m_unf = 0;
    end else begin
      int ins, outs, total;
      ins = 0; outs = 0;
      for (int i = 0; i < N; i++) begin
        if (m_phase[i] == P_ENTERED) ins++;
        if (m_phase[i] == P_EXITED)  outs++;
      end
      total = m_occ + ins - outs;
      m_ovf = total > CAP;
      m_unf = total < 0;
      m_occ = m_ovf ? CAP : (m_unf ? 0 : total);

      for (int i = 0; i < N; i++) begin
        bit up1, dn1, up2, dn2, expired;
        int next;
        up1 = m_s1_now[i] && !m_s1_prev[i];
        dn1 = !m_s1_now[i] && m_s1_prev[i];
        up2 = m_s2_now[i] && !m_s2_prev[i];
        dn2 = !m_s2_now[i] && m_s2_prev[i];
        expired = (m_dwell[i] == TO - 1);
        next = m_phase[i];
        m_fault[i] = 0;
        if (m_phase[i] == P_IDLE) begin
          if (up1 && !m_s2_now[i]) next = P_IN;
          else if (up2 && !m_s1_now[i]) next = P_OUT;
        end else if (m_phase[i] == P_IN) begin
          if (up2) next = P_ENTERED;
          else if (dn1) next = P_IDLE;
          else if (m_s2_now[i]) next = P_EXITED;
          else if (expired) begin next = P_IDLE; m_fault[i] = 1; end
        end else if (m_phase[i] == P_OUT) begin
          if (up1) next = P_EXITED;
          else if (dn2) next = P_IDLE;
          else if (m_s1_now[i]) next = P_ENTERED;
          else if (expired) begin next = P_IDLE; m_fault[i] = 1; end
        end else if (m_phase[i] == P_ENTERED || m_phase[i] == P_EXITED) begin
          next = P_CLEAR;
        end else begin
          if (!m_s1_now[i] && !m_s2_now[i]) next = P_IDLE;
          else if (expired) begin next = P_IDLE; m_fault[i] = 1; end
        end
        if (next != m_phase[i]) m_dwell[i] = 0;
        else if (next == P_IN || next == P_OUT || next == P_CLEAR) m_dwell[i]++;
        m_phase[i] = next;
      end
      m_s1_prev = m_s1_now; m_s2_prev = m_s2_now;
      m_s1_now = s1; m_s2_now = s2;
    end
  end

  int n_ent0 = 0, n_ent1 = 0, n_ex0 = 0, n_ex1 = 0, n_flt0 = 0, n_ovf = 0, n_unf = 0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("entering[%0d]", i), int'(entering[i]), int'(m_phase[i] == P_ENTERED));
      check($sformatf("exiting[%0d]", i), int'(exiting[i]), int'(m_phase[i] == P_EXITED));
      check($sformatf("lane_fault[%0d]", i), int'(lane_fault[i]), int'(m_fault[i]));
    end
    check("occupancy", int'(occupancy), m_occ);
    check("full", int'(full), int'(m_occ == CAP));
    check("empty", int'(empty), int'(m_occ == 0));
    check("overflow_err", int'(overflow_err), int'(m_ovf));
    check("underflow_err", int'(underflow_err), int'(m_unf));
    n_ent0 += int'(entering[0]); n_ent1 += int'(entering[1]);
    n_ex0  += int'(exiting[0]);  n_ex1  += int'(exiting[1]);
    n_flt0 += int'(lane_fault[0]);
    n_ovf  += int'(overflow_err); n_unf += int'(underflow_err);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_enter(input logic [N-1:0] m);
    s1 = s1 | m; tick(3);
    s2 = s2 | m; tick(3);
    s1 = s1 & ~m; tick(3);
    s2 = s2 & ~m; tick(4);
  endtask

  task automatic do_exit(input logic [N-1:0] m);
    s2 = s2 | m; tick(3);
    s1 = s1 | m; tick(3);
    s2 = s2 & ~m; tick(3);
    s1 = s1 & ~m; tick(4);
  endtask

  initial begin
    int b0, b1, b2, b3;
    reset_n = 1'b0; s1 = '0; s2 = '0;
    tick(3);
    check("reset occupancy", int'(occupancy), 0);
    check("reset empty", int'(empty), 1);
    check("reset full", int'(full), 0);
    reset_n = 1'b1;
    tick(2);

    // 1) entry on lane 0
    b0 = n_ent0;
    do_enter(2'b01);
    check("t1 entering0 pulses", n_ent0 - b0, 1);
    check("t1 occupancy", int'(occupancy), 1);
    check("t1 empty", int'(empty), 0);

    // 2) exit on lane 1, then an exit with nobody inside
    b0 = n_ex1; b1 = n_unf;
    do_exit(2'b10);
    check("t2 exiting1 pulses", n_ex1 - b0, 1);
    check("t2 occupancy", int'(occupancy), 0);
    check("t2 empty", int'(empty), 1);
    do_exit(2'b10);
    check("t2 underflow pulses", n_unf - b1, 1);
    check("t2 occupancy after underflow", int'(occupancy), 0);

    // 3) back-out
    b0 = n_ent0; b1 = n_ex0;
    s1 = 2'b01; tick(4); s1 = '0; tick(4);
    check("t3 backout pulses", (n_ent0 - b0) + (n_ex0 - b1), 0);
    check("t3 occupancy", int'(occupancy), 0);

    // 4) stuck outer sensor times out; later inner rise must not count
    b0 = n_flt0; b1 = n_ent0;
    s1 = 2'b01; tick(14);
    check("t4 fault pulses", n_flt0 - b0, 1);
    s2 = 2'b01; tick(4);
    check("t4 no entering after fault", n_ent0 - b1, 0);
    s1 = '0; s2 = '0; tick(4);

    // random traffic on both lanes
    for (int c = 0; c < 3000; c++) begin
      int rate;
      rate = (c % 600 < 300) ? 3 : 12;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, rate) == 0) s1[i] = ~s1[i];
        if ($urandom_range(0, rate) == 0) s2[i] = ~s2[i];
      end
      tick(1);
    end
    s1 = '0; s2 = '0; tick(TO + 4);

    // 5) fill to 14, double entry clamps at 15, then enter+exit nets out at full
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(2);
    for (int k = 0; k < 7; k++) do_enter(2'b11);
    check("t5 occupancy 14", int'(occupancy), 14);
    b0 = n_ovf;
    do_enter(2'b11);
    check("t5 occupancy clamped", int'(occupancy), 15);
    check("t5 full", int'(full), 1);
    check("t5 overflow pulses", n_ovf - b0, 1);
    b0 = n_ovf; b1 = n_unf; b2 = n_ent0; b3 = n_ex1;
    s1 = 2'b01; s2 = 2'b10; tick(3);
    s1 = 2'b11; s2 = 2'b11; tick(3);
    s1 = 2'b10; s2 = 2'b01; tick(3);
    s1 = '0; s2 = '0; tick(4);
    check("t5 mixed occupancy", int'(occupancy), 15);
    check("t5 mixed errors", (n_ovf - b0) + (n_unf - b1), 0);
    check("t5 mixed enter0", n_ent0 - b2, 1);
    check("t5 mixed exit1", n_ex1 - b3, 1);

    // 6) reset while lane 0 is mid-detection with occupancy 5
    for (int k = 0; k < 5; k++) do_exit(2'b11);
    check("t6 occupancy 5", int'(occupancy), 5);
    s1 = 2'b01; tick(2);
    reset_n = 1'b0; #1;
    check("t6 async occupancy", int'(occupancy), 0);
    check("t6 async empty", int'(empty), 1);
    check("t6 async pulses", int'({entering, exiting, lane_fault, overflow_err, underflow_err}), 0);
    tick(2);
    s1 = '0;
    b0 = n_ent0 + n_ex0 + n_ent1 + n_ex1 + n_flt0 + n_ovf + n_unf;
    reset_n = 1'b1; tick(TO + 4);
    check("t6 no stray pulses", n_ent0 + n_ex0 + n_ent1 + n_ex1 + n_flt0 + n_ovf + n_unf - b0, 0);
    check("t6 occupancy after", int'(occupancy), 0);
    check("t6 empty after", int'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
